// File: rtl/audio_ctrl_pkg.sv
// audio_pkg: shared constants, effect ROM and FSM state type for audio_ctrl
//   SFX_ROM[id][step] : 4 effects x 4 notes, 0 = rest (silence in note_gen)
package audio_pkg;
  localparam int ROM_W = 22;
  localparam logic [1:0] SFX_HIT = 2'd0;
  localparam logic [1:0] SFX_KEY = 2'd1;
  localparam logic [1:0] SFX_DOOR = 2'd2;
  localparam logic [1:0] SFX_OVER = 2'd3;
  localparam logic [2:0] VOL_MIN = 3'd1;
  localparam logic [2:0] VOL_MAX = 3'd5;
  localparam logic [2:0] VOL_RST = 3'd3;
  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;
  localparam logic [ROM_W-1:0] SFX_ROM [4][4] = '{
    '{22'd191110, 22'd151685, 22'd0,      22'd127551},
    '{22'd127551, 22'd101239, 22'd85131,  22'd63776},
    '{22'd255102, 22'd0,      22'd255102, 22'd191110},
    '{22'd127551, 22'd170264, 22'd227272, 22'd255102}
  };
endpackage

// File: rtl/audio_ctrl_if.sv
// audio_ctrl_if: tone-source inputs and note_gen-facing outputs of audio_ctrl
//   master drives bgm_div_l/r, sfx_req, vol_up, vol_down, mute
//   slave  drives note_div_l/r, volume, sfx_busy, sfx_id
interface audio_ctrl_if #(parameter int DIV_W = 22);
  logic [DIV_W-1:0] bgm_div_l;
  logic [DIV_W-1:0] bgm_div_r;
  logic [3:0] sfx_req;
  logic vol_up;
  logic vol_down;
  logic mute;
  logic [DIV_W-1:0] note_div_l;
  logic [DIV_W-1:0] note_div_r;
  logic [2:0] volume;
  logic sfx_busy;
  logic [1:0] sfx_id;
  modport master (
    output bgm_div_l, bgm_div_r, sfx_req, vol_up, vol_down, mute,
    input note_div_l, note_div_r, volume, sfx_busy, sfx_id
  );
  modport slave (
    input bgm_div_l, bgm_div_r, sfx_req, vol_up, vol_down, mute,
    output note_div_l, note_div_r, volume, sfx_busy, sfx_id
  );
endinterface

// File: rtl/audio_ctrl_sfx_prio_enc.sv
// sfx_prio_enc: 4-bit fixed-priority encoder, bit 3 highest
//   i_req : request bits   o_valid : any bit set   o_id : highest set bit index
module sfx_prio_enc (
  input  logic [3:0] i_req,
  output logic       o_valid,
  output logic [1:0] o_id
);
  assign o_valid = |i_req;
  assign o_id = i_req[3] ? 2'd3 : i_req[2] ? 2'd2 : i_req[1] ? 2'd1 : 2'd0;
endmodule

// File: rtl/audio_ctrl.sv
// audio_ctrl: arbitrates music vs 4-note sound effects onto note_gen, owns volume/mute
//   clk, rst (async, active-high), bus : audio_ctrl_if.slave
module audio_ctrl
  import audio_pkg::*;
#(
  parameter int STEP_CYCLES = 5_000_000,
  parameter int DIV_W = 22
) (
  input logic clk,
  input logic rst,
  audio_ctrl_if.slave bus
);
  localparam int CYC_W = $clog2(STEP_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(STEP_CYCLES - 1);
  state_t r_state, w_state;
  logic [1:0] r_id, w_id, r_step, w_step;
  logic [CYC_W-1:0] r_cyc, w_cyc;
  logic [2:0] r_vol, w_vol, r_volume;
  logic [DIV_W-1:0] r_div_l, r_div_r, w_rom;
  logic w_req_vld, w_last, w_take, w_up, w_dn;
  logic [1:0] w_req_id;
  sfx_prio_enc u_enc (
    .i_req(bus.sfx_req),
    .o_valid(w_req_vld),
    .o_id(w_req_id)
  );
  assign w_last = r_cyc == CYC_LAST;
  // equal priority restarts the running effect; lower is dropped
  assign w_take = w_req_vld && (r_state == IDLE || w_req_id >= r_id);
  always_comb begin
    w_state = r_state;
    w_id = r_id;
    w_step = r_step;
    w_cyc = r_cyc;
    if (r_state == PLAY) begin
      w_cyc = w_last ? '0 : r_cyc + 1'b1;
      w_step = r_step + {1'b0, w_last};
      if (w_last && r_step == 2'd3) w_state = IDLE;
    end
    if (w_take) begin
      w_state = PLAY;
      w_id = w_req_id;
      w_step = '0;
      w_cyc = '0;
    end
  end
  // outputs register the next-state note so the effect appears with sfx_busy
  assign w_rom = DIV_W'(SFX_ROM[w_id][w_step]);
  assign w_up = bus.vol_up & ~bus.vol_down & ~bus.mute & (r_vol < VOL_MAX);
  assign w_dn = bus.vol_down & ~bus.vol_up & ~bus.mute & (r_vol > VOL_MIN);
  assign w_vol = w_up ? r_vol + 3'd1 : w_dn ? r_vol - 3'd1 : r_vol;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_id <= '0;
      r_step <= '0;
      r_cyc <= '0;
      r_vol <= VOL_RST;
      r_volume <= VOL_RST;
      r_div_l <= '0;
      r_div_r <= '0;
    end else begin
      r_state <= w_state;
      r_id <= w_id;
      r_step <= w_step;
      r_cyc <= w_cyc;
      r_vol <= w_vol;
      r_volume <= bus.mute ? 3'd0 : w_vol;
      r_div_l <= w_state == PLAY ? w_rom : bus.bgm_div_l;
      r_div_r <= w_state == PLAY ? w_rom : bus.bgm_div_r;
    end
  end
  assign bus.note_div_l = r_div_l;
  assign bus.note_div_r = r_div_r;
  assign bus.volume = r_volume;
  assign bus.sfx_busy = r_state == PLAY;
  assign bus.sfx_id = r_state == PLAY ? r_id : 2'd0;
endmodule

// File: tb/tb_audio_ctrl.sv
// tb_audio_ctrl: scoreboard-driven self-checking bench for audio_ctrl (STEP_CYCLES = 4)
module tb_audio_ctrl;
  typedef struct packed {
    logic [3:0] req;
    logic up, dn, mute;
    logic [21:0] bgm_l, bgm_r;
  } stim_t;
  typedef struct packed {
    logic [21:0] l, r;
    logic [2:0] vol;
    logic busy;
    logic [1:0] id;
  } exp_t;
  localparam logic [21:0] BL = 22'h1234;
  localparam logic [21:0] BR = 22'h5678;
  localparam logic [21:0] ROM [4][4] = '{
    '{22'd191110, 22'd151685, 22'd0,      22'd127551},
    '{22'd127551, 22'd101239, 22'd85131,  22'd63776},
    '{22'd255102, 22'd0,      22'd255102, 22'd191110},
    '{22'd127551, 22'd170264, 22'd227272, 22'd255102}
  };
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  logic [2:0] cur_vol = 3'd3;
  stim_t sq[$];
  exp_t eq[$];
  audio_ctrl_if #(.DIV_W(22)) aif ();
  audio_ctrl #(.STEP_CYCLES(4), .DIV_W(22)) dut (.clk(clk), .rst(rst), .bus(aif));
  always #5 clk = ~clk;
  function automatic stim_t st(logic [3:0] r, logic u = 1'b0, logic d = 1'b0, logic m = 1'b0);
    return '{req: r, up: u, dn: d, mute: m, bgm_l: BL, bgm_r: BR};
  endfunction
  function automatic exp_t ex_mus();
    return '{l: BL, r: BR, vol: cur_vol, busy: 1'b0, id: 2'd0};
  endfunction
  function automatic exp_t ex_sfx(int id, int k);
    return '{l: ROM[id][k], r: ROM[id][k], vol: cur_vol, busy: 1'b1, id: 2'(id)};
  endfunction
  function automatic exp_t obs();
    return '{l: aif.note_div_l, r: aif.note_div_r, vol: aif.volume, busy: aif.sfx_busy, id: aif.sfx_id};
  endfunction
  function automatic void push(stim_t s, exp_t e);
    sq.push_back(s);
    eq.push_back(e);
  endfunction
  task automatic drive(input stim_t s);
    @(negedge clk);
    aif.sfx_req = s.req;
    aif.vol_up = s.up;
    aif.vol_down = s.dn;
    aif.mute = s.mute;
    aif.bgm_div_l = s.bgm_l;
    aif.bgm_div_r = s.bgm_r;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    exp_t e, o;
    int i = 0;
    aif.sfx_req = '0;
    aif.vol_up = 1'b0;
    aif.vol_down = 1'b0;
    aif.mute = 1'b0;
    aif.bgm_div_l = '0;
    aif.bgm_div_r = '0;
    repeat (2) @(posedge clk);
    #1;
    e = '{l: 22'd0, r: 22'd0, vol: 3'd3, busy: 1'b0, id: 2'd0};
    o = obs();
    total++;
    if (o !== e) $display("FAIL reset_state got %h exp %h", o, e);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    push(st(4'b0000), ex_mus());
    push(st(4'b0000), ex_mus());
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front();
      o = obs();
      total++;
      if (o !== e) $display("FAIL passthru[%0d] got %h exp %h", i, o, e);
      else passed++;
      i++;
    end
  endtask
  task automatic test_single();
    exp_t e, o;
    int i = 0;
    push(st(4'b0001), ex_sfx(0, 0));
    for (int k = 1; k < 16; k++) push(st(4'b0000), ex_sfx(0, k / 4));
    push(st(4'b0000), ex_mus());
    push(st(4'b0000), ex_mus());
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front();
      o = obs();
      total++;
      if (o !== e) $display("FAIL single[%0d] got %h exp %h", i, o, e);
      else passed++;
      i++;
    end
  endtask
  task automatic test_preempt();
    exp_t e, o;
    int i = 0;
    push(st(4'b0110), ex_sfx(2, 0));
    for (int k = 1; k < 9; k++) push(st(4'b0000), ex_sfx(2, k / 4));
    push(st(4'b1000), ex_sfx(3, 0));
    for (int k = 10; k < 25; k++) push(st(4'b0000), ex_sfx(3, (k - 9) / 4));
    push(st(4'b0000), ex_mus());
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front();
      o = obs();
      total++;
      if (o !== e) $display("FAIL preempt[%0d] got %h exp %h", i, o, e);
      else passed++;
      i++;
    end
  endtask
  task automatic test_low_prio_drop();
    exp_t e, o;
    int i = 0;
    push(st(4'b0100), ex_sfx(2, 0));
    for (int k = 1; k < 16; k++) push(st(k == 5 ? 4'b0001 : 4'b0000), ex_sfx(2, k / 4));
    push(st(4'b0000), ex_mus());
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front();
      o = obs();
      total++;
      if (o !== e) $display("FAIL low_prio[%0d] got %h exp %h", i, o, e);
      else passed++;
      i++;
    end
  endtask
  task automatic test_back_to_back();
    exp_t e, o;
    int i = 0;
    push(st(4'b0010), ex_sfx(1, 0));
    for (int k = 1; k < 16; k++) push(st(4'b0000), ex_sfx(1, k / 4));
    push(st(4'b0010), ex_sfx(1, 0));
    for (int k = 17; k < 32; k++) push(st(4'b0000), ex_sfx(1, (k - 16) / 4));
    push(st(4'b0000), ex_mus());
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front();
      o = obs();
      total++;
      if (o !== e) $display("FAIL collision[%0d] got %h exp %h", i, o, e);
      else passed++;
      i++;
    end
  endtask
  task automatic test_volume();
    exp_t e, o;
    int i = 0;
    cur_vol = 3'd4;
    push(st(4'b0000, 1'b1), ex_mus());
    cur_vol = 3'd5;
    push(st(4'b0000, 1'b1), ex_mus());
    push(st(4'b0000, 1'b1), ex_mus());
    cur_vol = 3'd0;
    push(st(4'b0000, 1'b0, 1'b0, 1'b1), ex_mus());
    push(st(4'b0000, 1'b0, 1'b1, 1'b1), ex_mus());
    cur_vol = 3'd5;
    push(st(4'b0000), ex_mus());
    push(st(4'b0000, 1'b1, 1'b1), ex_mus());
    for (int k = 0; k < 6; k++) begin
      cur_vol = k < 4 ? 3'(4 - k) : 3'd1;
      push(st(4'b0000, 1'b0, 1'b1), ex_mus());
    end
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front();
      o = obs();
      total++;
      if (o !== e) $display("FAIL volume[%0d] got %h exp %h", i, o, e);
      else passed++;
      i++;
    end
  endtask
  task automatic test_async_reset();
    exp_t e, o;
    int i = 0;
    push(st(4'b1000), ex_sfx(3, 0));
    for (int k = 1; k < 6; k++) push(st(4'b0000), ex_sfx(3, k / 4));
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      e = eq.pop_front();
      o = obs();
      total++;
      if (o !== e) $display("FAIL pre_abort[%0d] got %h exp %h", i, o, e);
      else passed++;
      i++;
    end
    #1;
    rst = 1'b1;
    #1;
    e = '{l: 22'd0, r: 22'd0, vol: 3'd3, busy: 1'b0, id: 2'd0};
    o = obs();
    total++;
    if (o !== e) $display("FAIL async_abort got %h exp %h", o, e);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cur_vol = 3'd3;
    e = ex_mus();
    o = obs();
    total++;
    if (o !== e) $display("FAIL post_reset_music got %h exp %h", o, e);
    else passed++;
  endtask
  initial begin
    test_reset();
    test_single();
    test_preempt();
    test_low_prio_drop();
    test_back_to_back();
    test_volume();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/audio_ctrl.md
# audio_ctrl

Audio sequencer and arbiter between the game's tone sources and the shared `note_gen` datapath. It takes the background-music divisors from `game_sound` and one-cycle sound-effect requests from `game_play`. It grants the single tone channel to either music or one effect and plays effects as fixed 4-note sequences. It also owns the volume/mute register. The registered outputs drive `note_gen`'s `note_div_left`/`note_div_right` and `volume` inputs directly.

## Interface
- `STEP_CYCLES`, 5_000_000, clk cycles per effect note (50 ms at 100 MHz); must be ≥ 2
- `DIV_W`, 22, width of a note divisor
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  reset: asynchronous, active-high; clock is `clk`
- `bgm_div_l`  in  DIV_W  music divisor, left channel
- `bgm_div_r`  in  DIV_W  music divisor, right channel
- `sfx_req`  in  4  one-cycle effect request pulses: [0] hit, [1] key found, [2] door, [3] game over
- `vol_up`  in  1  one-cycle pulse, already debounced
- `vol_down`  in  1  one-cycle pulse, already debounced
- `mute`  in  1  level input
- `note_div_l`  out  DIV_W  divisor to `note_gen`, left channel
- `note_div_r`  out  DIV_W  divisor to `note_gen`, right channel
- `volume`  out  3  effective volume to `note_gen`
- `sfx_busy`  out  1  an effect currently owns the channel
- `sfx_id`  out  2  index of the playing effect; 0 when idle

## Operation
- FSM has two states, IDLE and PLAY. Registers: `cur_id[1:0]`, `step[1:0]`, `cyc` (width `$clog2(STEP_CYCLES)`), `vol_reg[2:0]`.
- **Request selection:** the winner is the highest set bit of `sfx_req` (fixed priority, game over highest).
- **IDLE:**
  - Outputs pass music through: `note_div_l/r <= bgm_div_l/r` (registered).
  - Any request: load `cur_id` = winner, `step` = 0, `cyc` = 0, and go to PLAY.
- **PLAY:**
  - Both channels output `SFX_ROM[cur_id][step]`.
  - `cyc` increments each cycle. At `cyc == STEP_CYCLES-1`: `cyc` goes to 0 and `step` increments.
  - When `step == 3` and `cyc == STEP_CYCLES-1`, return to IDLE.
- **Preemption:**
  - In PLAY, a request whose winner ≥ `cur_id` restarts the sequence: new `cur_id`, `step` = 0, `cyc` = 0.
  - A lower-priority request is dropped. Requests are never queued.
- **Completion plus new request in the same cycle:** the request wins. The block stays in PLAY with the new effect at step 0.
- **ROM entries:** a ROM entry of 0 is a rest. It passes 0, meaning silence per the `note_gen` convention.
- **Volume:**
  - `vol_reg` resets to 3 and is clamped to 1..5.
  - `vol_up` adds 1 if `vol_reg` < 5; `vol_down` subtracts 1 if `vol_reg` > 1.
  - `vol_up` and `vol_down` in the same cycle: no change.
  - While `mute` = 1, pulses are ignored and `vol_reg` holds its value.
  - `volume` = `mute ? 0 : vol_reg`, registered.

## Timing
- **Reset values:** `note_div_l/r` = 0, `volume` = 3, `sfx_busy` = 0, `sfx_id` = 0, FSM in IDLE.
- **Asynchronous reset mid-effect:** aborts the effect immediately; the first post-reset cycle is music pass-through.
- **Request latency:** `sfx_req` pulse at edge N → effect note on `note_div_*` and `sfx_busy` = 1 after edge N+1.
- **Effect length:** busy for exactly 4·STEP_CYCLES cycles, then music resumes on the next cycle.
- **Music latency:** pass-through is one cycle.
- **Volume/mute latency:** one cycle from pulse or level change to `volume`.

## Structure
- Package `audio_pkg` holds:
  - the `SFX_ROM` constant array [4][4] of DIV_W-bit divisors;
  - localparams for the effect IDs (`SFX_HIT`, `SFX_KEY`, `SFX_DOOR`, `SFX_OVER`);
  - `VOL_MIN` = 1, `VOL_MAX` = 5, `VOL_RST` = 3;
  - the state enum.
- One sub-module, `sfx_prio_enc`: 4-bit fixed-priority encoder producing `{valid, id[1:0]}`.
- Volume logic stays inline. The `volume` register moves out of `top` into this block.

## Test plan
All scenarios run with STEP_CYCLES = 4.
- **Reset and pass-through:** after reset, `bgm_div_l` = 0x1234 → `note_div_l` = 0x1234 one cycle later; `volume` = 3; `sfx_busy` = 0.
- **Single effect:** `sfx_req` = 0001 for one cycle → `sfx_busy` high for exactly 16 cycles; ROM[0][0..3] each shown for 4 cycles; then `note_div` = music.
- **Simultaneous requests:** `sfx_req` = 0110 → `sfx_id` = 2.
- **Preemption:**
  - During effect 2 at step 2, `sfx_req` = 1000 → `sfx_id` = 3, step 0, 16 further busy cycles.
  - During effect 2, `sfx_req` = 0001 → ignored; effect 2 ends on schedule.
- **Completion collision:** request 0010 on the final cycle of effect 1 → `sfx_busy` stays 1 with no gap and `sfx_id` = 1, step 0.
- **Volume:**
  - 3 `vol_up` pulses → 5 (clamped).
  - `mute` = 1 → `volume` = 0; `vol_down` while muted is ignored.
  - `mute` = 0 → 5.
  - `vol_up` and `vol_down` in the same cycle → unchanged.
  - 6 `vol_down` pulses → 1.
